// File: rtl/fdtd_pkg.sv
// Shared definitions for the FDTD accelerator control blocks: scheduler state
// encoding and default sizing of the step and watchdog counters.
package fdtd_pkg;

    localparam int DEF_STEP_CNT_WIDTH = 16;
    localparam int DEF_WDOG_WIDTH     = 12;
    localparam int DEF_WDOG_LIMIT     = 4000;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ISSUE_HY  = 4'd1,
        S_WAIT_HY   = 4'd2,
        S_ISSUE_EZ  = 4'd3,
        S_WAIT_EZ   = 4'd4,
        S_ISSUE_SRC = 4'd5,
        S_WAIT_SRC  = 4'd6,
        S_NEXT_STEP = 4'd7,
        S_DONE      = 4'd8,
        S_ERR       = 4'd9
    } sched_state_e;

endpackage

// File: rtl/fdtd_step_sched.sv
// Time-step scheduler: sequences Hy, Ez and source phases per step, waits for
// each write-back, counts steps and flags completion or a stalled phase.
module fdtd_step_sched
    import fdtd_pkg::*;
#(
    parameter int STEP_CNT_WIDTH = DEF_STEP_CNT_WIDTH,
    parameter int WDOG_WIDTH     = DEF_WDOG_WIDTH,
    parameter int WDOG_LIMIT     = DEF_WDOG_LIMIT
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [STEP_CNT_WIDTH-1:0] step_num_i,
    input  logic [STEP_CNT_WIDTH-1:0] src_len_i,
    input  logic                      Hy_wb_done_i,
    input  logic                      Ez_wb_done_i,
    input  logic                      src_wb_done_i,
    input  logic                      irq_clr_i,
    output logic                      calc_Hy_flg_o,
    output logic                      calc_Ez_flg_o,
    output logic                      calc_src_flg_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      irq_o,
    output logic [STEP_CNT_WIDTH-1:0] step_cnt_o
);

    localparam logic [WDOG_WIDTH-1:0]     WDOG_LIM_V = WDOG_WIDTH'(WDOG_LIMIT);
    localparam logic [WDOG_WIDTH-1:0]     WDOG_EXP_V = WDOG_WIDTH'(WDOG_LIMIT - 1);
    localparam logic [WDOG_WIDTH-1:0]     WDOG_ONE_V = WDOG_WIDTH'(1);
    localparam logic [STEP_CNT_WIDTH-1:0] STEP_ONE_V = STEP_CNT_WIDTH'(1);

    sched_state_e              state_r;
    sched_state_e              state_nxt_s;
    logic [STEP_CNT_WIDTH-1:0] step_num_r;
    logic [STEP_CNT_WIDTH-1:0] src_len_r;
    logic [STEP_CNT_WIDTH-1:0] step_cnt_r;
    logic [STEP_CNT_WIDTH-1:0] step_cnt_inc_s;
    logic [WDOG_WIDTH-1:0]     wdog_r;
    logic                      err_r;
    logic                      irq_r;
    logic                      abort_s;
    logic                      start_take_s;
    logic                      in_wait_s;
    logic                      in_issue_s;
    logic                      wdog_exp_s;
    logic                      enter_err_s;
    logic                      irq_set_s;

    assign abort_s        = abort_i && (state_r != S_IDLE);
    assign start_take_s   = start_i && !abort_s &&
                            ((state_r == S_IDLE) || (state_r == S_ERR));
    assign in_wait_s      = (state_r == S_WAIT_HY) || (state_r == S_WAIT_EZ) ||
                            (state_r == S_WAIT_SRC);
    assign in_issue_s     = (state_r == S_ISSUE_HY) || (state_r == S_ISSUE_EZ) ||
                            (state_r == S_ISSUE_SRC);
    assign wdog_exp_s     = (wdog_r >= WDOG_EXP_V);
    assign step_cnt_inc_s = step_cnt_r + STEP_ONE_V;
    assign enter_err_s    = (state_nxt_s == S_ERR) && (state_r != S_ERR);
    assign irq_set_s      = enter_err_s || ((state_r == S_DONE) && !abort_s);

    // Phase sequencing; abort overrides everything, a write-back beats the watchdog.
    always_comb begin
        state_nxt_s = state_r;
        if (abort_s) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE, S_ERR: begin
                    if (start_i) begin
                        state_nxt_s = (step_num_i == '0) ? S_DONE : S_ISSUE_HY;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                S_ISSUE_HY:  state_nxt_s = S_WAIT_HY;
                S_WAIT_HY: begin
                    if (Hy_wb_done_i)    state_nxt_s = S_ISSUE_EZ;
                    else if (wdog_exp_s) state_nxt_s = S_ERR;
                    else                 state_nxt_s = S_WAIT_HY;
                end
                S_ISSUE_EZ:  state_nxt_s = S_WAIT_EZ;
                S_WAIT_EZ: begin
                    if (Ez_wb_done_i) begin
                        state_nxt_s = (step_cnt_r < src_len_r) ? S_ISSUE_SRC : S_NEXT_STEP;
                    end else if (wdog_exp_s) begin
                        state_nxt_s = S_ERR;
                    end else begin
                        state_nxt_s = S_WAIT_EZ;
                    end
                end
                S_ISSUE_SRC: state_nxt_s = S_WAIT_SRC;
                S_WAIT_SRC: begin
                    if (src_wb_done_i)   state_nxt_s = S_NEXT_STEP;
                    else if (wdog_exp_s) state_nxt_s = S_ERR;
                    else                 state_nxt_s = S_WAIT_SRC;
                end
                S_NEXT_STEP: begin
                    state_nxt_s = (step_cnt_inc_s == step_num_r) ? S_DONE : S_ISSUE_HY;
                end
                S_DONE:      state_nxt_s = S_IDLE;
                default:     state_nxt_s = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_r <= S_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Run parameters are captured once per start; the step count stops at step_num.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            step_num_r <= '0;
            src_len_r  <= '0;
            step_cnt_r <= '0;
        end else if (start_take_s) begin
            step_num_r <= step_num_i;
            src_len_r  <= src_len_i;
            step_cnt_r <= '0;
        end else if ((state_r == S_NEXT_STEP) && !abort_s) begin
            step_cnt_r <= step_cnt_inc_s;
        end else begin
            step_cnt_r <= step_cnt_r;
        end
    end

    // Per-phase watchdog: cleared on issue, counts while waiting, saturates at the limit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wdog_r <= '0;
        end else if (in_issue_s) begin
            wdog_r <= '0;
        end else if (in_wait_s && (wdog_r < WDOG_LIM_V)) begin
            wdog_r <= wdog_r + WDOG_ONE_V;
        end else begin
            wdog_r <= wdog_r;
        end
    end

    // Sticky error and level interrupt; a set wins over a same-cycle clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_r <= 1'b0;
            irq_r <= 1'b0;
        end else begin
            if (start_take_s)     err_r <= 1'b0;
            else if (enter_err_s) err_r <= 1'b1;
            else                  err_r <= err_r;

            if (irq_set_s)        irq_r <= 1'b1;
            else if (irq_clr_i)   irq_r <= 1'b0;
            else                  irq_r <= irq_r;
        end
    end

    assign calc_Hy_flg_o  = (state_r == S_ISSUE_HY);
    assign calc_Ez_flg_o  = (state_r == S_ISSUE_EZ);
    assign calc_src_flg_o = (state_r == S_ISSUE_SRC);
    assign done_o         = (state_r == S_DONE);
    assign busy_o         = (state_r != S_IDLE) && (state_r != S_ERR);
    assign err_o          = err_r;
    assign irq_o          = irq_r;
    assign step_cnt_o     = step_cnt_r;

endmodule

// File: doc/fdtd_step_sched.md
# fdtd_step_sched

Time-step scheduler for the FDTD accelerator. It sits between the plugin's register interface and `fdtd_calc_ctrl`. For a programmed number of time steps it issues the Hy-update, Ez-update and source-injection phase requests in order. Before issuing the next phase it waits for the memory controller to report that the previous phase's write-back has finished. It counts completed steps, signals completion and raises an interrupt, and aborts with an error if a phase stalls.

## Interface
- `STEP_CNT_WIDTH`, 16, width of step count and source-length values
- `WDOG_WIDTH`, 12, width of per-phase watchdog counter
- `WDOG_LIMIT`, 4000, cycles allowed in any WAIT state before error
- `CLK` in 1: single clock, rising edge
- `RST_N` in 1: asynchronous, active-low reset
- `start_i` in 1: begin run (sampled in IDLE, DONE-idle or ERR only)
- `abort_i` in 1: terminate run immediately
- `step_num_i` in STEP_CNT_WIDTH: total time steps, latched on start
- `src_len_i` in STEP_CNT_WIDTH: source injected in steps 0..src_len-1, latched on start
- `Hy_wb_done_i`, `Ez_wb_done_i`, `src_wb_done_i` in 1 each: write-back-complete pulses from mem_ctrl
- `irq_clr_i` in 1: clear `irq_o`
- `calc_Hy_flg_o`, `calc_Ez_flg_o`, `calc_src_flg_o` out 1 each: one-cycle phase requests to `fdtd_calc_ctrl`
- `busy_o` out 1: run in progress
- `done_o` out 1: one-cycle completion pulse
- `err_o` out 1: watchdog expired, sticky until next start
- `irq_o` out 1: level interrupt, set on done or error
- `step_cnt_o` out STEP_CNT_WIDTH: completed steps

## Operation
- States: IDLE, ISSUE_HY, WAIT_HY, ISSUE_EZ, WAIT_EZ, ISSUE_SRC, WAIT_SRC, NEXT_STEP, DONE, ERR.
- IDLE with `start_i` high:
  - Latch `step_num_i` and `src_len_i`; clear `step_cnt_o` and `err_o`.
  - If `step_num_i == 0`, go to DONE; otherwise go to ISSUE_HY.
- Each ISSUE_x lasts one cycle: it asserts the matching `calc_*_flg_o`, clears the watchdog and goes to WAIT_x.
- WAIT_HY exits to ISSUE_EZ on `Hy_wb_done_i`.
- WAIT_EZ exits on `Ez_wb_done_i`: to ISSUE_SRC if `step_cnt < src_len`, else to NEXT_STEP.
- WAIT_SRC exits to NEXT_STEP on `src_wb_done_i`.
- A done pulse is ignored in every state other than its matching WAIT state.
- NEXT_STEP lasts one cycle:
  - Increments `step_cnt`.
  - Goes to DONE if the incremented value equals the latched `step_num`; otherwise goes to ISSUE_HY.
- DONE lasts one cycle: it asserts `done_o`, sets `irq_o` and returns to IDLE.
- Watchdog:
  - Increments each cycle in a WAIT state and saturates at `WDOG_LIMIT`.
  - On reaching `WDOG_LIMIT`, go to ERR, set `err_o` and `irq_o`.
  - ERR holds until `start_i` (treated as in IDLE) or `abort_i` (go to IDLE, `err_o` kept).
- `abort_i` in any non-IDLE state:
  - Next state is IDLE; no flag, done or irq is produced.
  - `step_cnt_o` keeps its value.
  - `abort_i` has priority over all other transitions.
- `start_i` is ignored while `busy_o` is high.
- `busy_o` = state ∉ {IDLE, ERR}.
- `irq_o`: set has priority over `irq_clr_i` in the same cycle.
- Counters:
  - `step_cnt` is compared unsigned at full width and never wraps, since it stops at `step_num`.
  - The watchdog is WDOG_WIDTH wide; `WDOG_LIMIT` must be less than 2^WDOG_WIDTH.

## Timing
- Reset values:
  - State is IDLE.
  - All flags, `busy_o`, `done_o`, `err_o`, `irq_o` are 0; `step_cnt_o` is 0.
  - Latched values and watchdog are 0.
- Reset mid-run returns to IDLE asynchronously with no pulses.
- All outputs are registered or decoded from registered state; there is no combinational path from input to output.
- `start_i` sampled at edge k gives `calc_Hy_flg_o` high during cycle k+1 and `busy_o` high from k+1.
- A write-back done sampled at edge k gives the next `calc_*_flg_o` during cycle k+1 (Hy→Ez), or k+2 when the path goes through NEXT_STEP (→Hy of next step).
- The final done pulse sampled at edge k gives NEXT_STEP in k+1, `done_o` in k+2, and `irq_o` high from k+3.
- `step_num_i == 0` at start edge k gives `done_o` in cycle k+1.
- Watchdog error is raised `WDOG_LIMIT` cycles after entering WAIT.

## Structure
- `fdtd_pkg`:
  - `sched_state_e` enum (4-bit).
  - Default `STEP_CNT_WIDTH`, `WDOG_WIDTH` and `WDOG_LIMIT` constants.
  - Shared with `fdtd_calc_ctrl`.
- A single module with no sub-modules; the watchdog is one counter process, not a separate block.

## Test plan
- `step_num=2`, `src_len=1`, each wb-done returned 6 cycles after its flag → flag order Hy, Ez, src, Hy, Ez; `step_cnt_o` 1 then 2; one `done_o`; `irq_o` set.
- `step_num=0` → `done_o` in cycle after start, no `calc_*_flg_o`, `step_cnt_o=0`.
- `step_num=3`, `Ez_wb_done_i` withheld in step 1 → `err_o` and `irq_o` exactly `WDOG_LIMIT` cycles after WAIT_EZ entry; `busy_o=0`; `step_cnt_o=1`.
- `abort_i` during WAIT_HY of step 2 → IDLE next cycle, no `done_o`, `step_cnt_o=2`; a later start runs cleanly from 0.
- `start_i` pulsed in WAIT_EZ, spurious `Hy_wb_done_i` in WAIT_EZ → both ignored; sequence unaffected.
- `irq_clr_i` asserted in the same cycle as the irq set from DONE → `irq_o` stays 1; clear in the next cycle → 0.
